rf_bank: RTL

RF_BANK -- requirements
Module: rf_bank

---
 rtl/rf_bank_if.sv | 30 +++
 rtl/rf_bank.sv | 127 ++++++++++++
 2 files changed

// File: rtl/rf_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_bank_if
// Description : Read/write/clear bus of the rf_bank register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_bank_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0]        w_addr;
    logic [DATA_W-1:0]        wdata;
    logic                     we;
    logic                     clr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic                     busy;

    modport master (
        output r_addr, w_addr, wdata, we, clr,
        input  rdata, busy
    );

    modport slave (
        input  r_addr, w_addr, wdata, we, clr,
        output rdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/rf_bank.sv
`default_nettype none
// ============================================================================
// Module      : rf_bank
// Description : Flop-based register file, multi-port registered reads, entry 0
//               hard-wired to zero, bulk clear engine. Optional write-through
//               bypass enabled by macro RF_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_bank #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6,
    parameter int NUM_RD = 2
) (
    input  wire         clk,
    input  wire         rst_n,
    rf_bank_if.slave    bus
);

    localparam int              DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_ONE  = ADDR_W'(1);

`ifdef RF_BYPASS_EN
    localparam bit c_BYPASS = 1'b1;
`else
    localparam bit c_BYPASS = 1'b0;
`endif

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic              w_clr_en;
    logic              w_wr_en;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd  [NUM_RD];
    logic [ADDR_W-1:0] w_raddr [NUM_RD];
    logic [NUM_RD*DATA_W-1:0] w_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_clr_en    = 1'b0;
        w_wr_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A simultaneous clear request drops the write.
                if (bus.clr) begin
                    w_state_nxt = S_CLEAR;
                    w_ptr_nxt   = c_ONE;
                end else if (bus.we && (bus.w_addr != '0)) begin
                    w_wr_en = 1'b1;
                end
            end
            S_CLEAR: begin
                w_clr_en = 1'b1;
                if (r_ptr == c_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_ptr_nxt = r_ptr + c_ONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else if (w_clr_en) begin
            r_mem[r_ptr] <= '0;
        end else if (w_wr_en) begin
            r_mem[bus.w_addr] <= bus.wdata;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            w_raddr[i] = bus.r_addr[i*ADDR_W +: ADDR_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RD; i++) begin
                r_rd[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                if ((r_state == S_CLEAR) || (w_raddr[i] == '0)) begin
                    r_rd[i] <= '0;
                end else if (c_BYPASS && w_wr_en && (w_raddr[i] == bus.w_addr)) begin
                    r_rd[i] <= bus.wdata;
                end else begin
                    r_rd[i] <= r_mem[w_raddr[i]];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            w_rdata[i*DATA_W +: DATA_W] = r_rd[i];
        end
    end

    assign bus.rdata = w_rdata;
    assign bus.busy  = (r_state == S_CLEAR);

endmodule
`default_nettype wire
